multi_port_free_list: RTL and testbench

Parametrised physical-register free list for the rename stage. It is a circular buffer of physical register numbers with N in-order allocate (pop) lanes, M release (push) lanes, and a rollback mode that rewinds the head to return speculatively allocated registers. One instance serves scalar integer registers (PSCALAR_NUM − LSCALAR_NUM entries). A second instance serves FP registers (PSCALAR_FP_NUM − LSCALAR_FP_NUM entries). Both sit beside the RMT in the rename stage.

---
 rtl/multi_port_free_list.sv | 211 +++++++++++++++++++++
 tb/tb_multi_port_free_list.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_free_list.sv
// multi_port_free_list: circular buffer of free physical register numbers.
// Several in-order allocate lanes pop from the head, several release lanes
// push at the tail, and a rollback rewinds the head to hand back registers
// that were allocated on a squashed path. Pointers wrap modulo ENTRY_NUM by
// compare-and-subtract so the depth need not be a power of two.
module multi_port_free_list #(
    parameter int ENTRY_NUM  = 32,
    parameter int DATA_WIDTH = 6,
    parameter int POP_WIDTH  = 2,
    parameter int PUSH_WIDTH = 2,
    parameter int INIT_BASE  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [POP_WIDTH-1:0]             popReq,
    output logic [POP_WIDTH*DATA_WIDTH-1:0]  popData,
    output logic                             allocatable,
    input  logic [PUSH_WIDTH-1:0]            pushReq,
    input  logic [PUSH_WIDTH*DATA_WIDTH-1:0] pushData,
    input  logic                             rollback,
    input  logic [$clog2(ENTRY_NUM):0]       rollbackCount,
    output logic [$clog2(ENTRY_NUM):0]       count,
    output logic                             empty
);

    localparam int PTR_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = PTR_W + 1;
    // One extra bit so pointer + increment never overflows before the wrap compare.
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH = SUM_W'(ENTRY_NUM);

    logic [DATA_WIDTH-1:0] entry_r [ENTRY_NUM];
    logic [PTR_W-1:0]      headPtr_r;
    logic [PTR_W-1:0]      tailPtr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  empty_r;

    logic [CNT_W-1:0]      popCnt_s;
    logic [CNT_W-1:0]      pushCnt_s;
    logic [CNT_W-1:0]      popAdv_s;
    logic [CNT_W-1:0]      countNext_s;
    logic [SUM_W-1:0]      countSum_s;
    logic [PTR_W-1:0]      headNext_s;
    logic [PTR_W-1:0]      tailNext_s;
    logic [PTR_W-1:0]      pushIdx_s [PUSH_WIDTH];
    logic                  popOk_s;

    // (ptr + inc) mod ENTRY_NUM; inc never exceeds ENTRY_NUM.
    function automatic logic [PTR_W-1:0] wrapAdd(input logic [PTR_W-1:0] ptr,
                                                 input logic [CNT_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(ptr) + SUM_W'(inc);
        if (sum >= DEPTH) begin
            sum = sum - DEPTH;
        end else begin
            sum = sum;
        end
        return PTR_W'(sum);
    endfunction

    // (ptr - dec) mod ENTRY_NUM; dec never exceeds ENTRY_NUM.
    function automatic logic [PTR_W-1:0] wrapSub(input logic [PTR_W-1:0] ptr,
                                                 input logic [CNT_W-1:0] dec);
        logic [SUM_W-1:0] diff;
        if (SUM_W'(ptr) >= SUM_W'(dec)) begin
            diff = SUM_W'(ptr) - SUM_W'(dec);
        end else begin
            diff = SUM_W'(ptr) + DEPTH - SUM_W'(dec);
        end
        return PTR_W'(diff);
    endfunction

    function automatic logic [CNT_W-1:0] popCount(input logic [POP_WIDTH-1:0] req);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < POP_WIDTH; i++) begin
            c = c + CNT_W'(req[i]);
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] pushCount(input logic [PUSH_WIDTH-1:0] req);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            c = c + CNT_W'(req[i]);
        end
        return c;
    endfunction

    // Grant compaction: the k-th requesting lane reads the entry k slots past the head.
    always_comb begin
        logic [CNT_W-1:0] rank;
        rank    = {CNT_W{1'b0}};
        popData = {(POP_WIDTH*DATA_WIDTH){1'b0}};
        for (int j = 0; j < POP_WIDTH; j++) begin
            popData[j*DATA_WIDTH +: DATA_WIDTH] = entry_r[wrapAdd(headPtr_r, rank)];
            rank = rank + CNT_W'(popReq[j]);
        end
    end

    // Release slot selection: the k-th releasing lane writes k slots past the tail.
    always_comb begin
        logic [CNT_W-1:0] rank;
        rank = {CNT_W{1'b0}};
        for (int j = 0; j < PUSH_WIDTH; j++) begin
            pushIdx_s[j] = wrapAdd(tailPtr_r, rank);
            rank = rank + CNT_W'(pushReq[j]);
        end
    end

    // Grant check plus next-state pointers and count; rollback overrides any pop.
    always_comb begin
        popCnt_s    = popCount(popReq);
        pushCnt_s   = pushCount(pushReq);
        allocatable = (count_r >= popCnt_s);
        popOk_s     = allocatable && !rollback;
        if (popOk_s) begin
            popAdv_s = popCnt_s;
        end else begin
            popAdv_s = {CNT_W{1'b0}};
        end
        if (rollback) begin
            headNext_s = wrapSub(headPtr_r, rollbackCount);
            countSum_s = SUM_W'(count_r) + SUM_W'(pushCnt_s) + SUM_W'(rollbackCount);
        end else begin
            headNext_s = wrapAdd(headPtr_r, popAdv_s);
            // popAdv_s <= count_r whenever it is non-zero, so this never underflows.
            countSum_s = SUM_W'(count_r) + SUM_W'(pushCnt_s) - SUM_W'(popAdv_s);
        end
        tailNext_s  = wrapAdd(tailPtr_r, pushCnt_s);
        countNext_s = CNT_W'(countSum_s);
    end

    // Pointer, count and empty-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headPtr_r <= {PTR_W{1'b0}};
            tailPtr_r <= {PTR_W{1'b0}};
            count_r   <= CNT_W'(ENTRY_NUM);
            empty_r   <= 1'b0;
        end else begin
            headPtr_r <= headNext_s;
            tailPtr_r <= tailNext_s;
            count_r   <= countNext_s;
            empty_r   <= (countNext_s == {CNT_W{1'b0}});
        end
    end

    // Storage: preloaded with consecutive register numbers, written by releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                entry_r[i] <= DATA_WIDTH'(INIT_BASE + i);
            end
        end else begin
            for (int j = 0; j < PUSH_WIDTH; j++) begin
                if (pushReq[j]) begin
                    entry_r[pushIdx_s[j]] <= pushData[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign count = count_r;
    assign empty = empty_r;

endmodule

// multi_port_free_list_checker: protocol assertions for the free list ports.
// Instantiated beside the free list; enable lets the surrounding environment
// mask cycles where a violation is intentional.
module multi_port_free_list_checker #(
    parameter int ENTRY_NUM  = 32,
    parameter int POP_WIDTH  = 2,
    parameter int PUSH_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [POP_WIDTH-1:0]       popReq,
    input  logic [PUSH_WIDTH-1:0]      pushReq,
    input  logic                       rollback,
    input  logic [$clog2(ENTRY_NUM):0] rollbackCount,
    input  logic                       allocatable,
    input  logic [$clog2(ENTRY_NUM):0] count
);

    int nextCount_s;

    // Count the free list will hold after this edge, computed from the ports.
    always_comb begin
        if (rollback) begin
            nextCount_s = int'(count) + $countones(pushReq) + int'(rollbackCount);
        end else if (allocatable) begin
            nextCount_s = int'(count) + $countones(pushReq) - $countones(popReq);
        end else begin
            nextCount_s = int'(count) + $countones(pushReq);
        end
    end

    popWhileBlocked: assert property (@(posedge clk) disable iff (rst || !enable)
        ((|popReq) && !rollback) |-> allocatable);

    pushOverflow: assert property (@(posedge clk) disable iff (rst || !enable)
        nextCount_s <= ENTRY_NUM);

    rollbackRange: assert property (@(posedge clk) disable iff (rst || !enable)
        rollback |-> ((int'(count) + int'(rollbackCount)) <= ENTRY_NUM));

endmodule

// File: tb/tb_multi_port_free_list.sv
`timescale 1ns/1ps
module tb_multi_port_free_list;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Instance A: 32 entries, preload 32..63
    logic [1:0]  popReqA, pushReqA;
    logic [11:0] popDataA, pushDataA;
    logic        rollbackA, allocA, emptyA, chkEnA;
    logic [5:0]  rbcA, countA;

    // Instance B: 24 entries, preload 32..55
    logic [1:0]  popReqB, pushReqB;
    logic [11:0] popDataB, pushDataB;
    logic        rollbackB, allocB, emptyB;
    logic [5:0]  rbcB, countB;

    int nChecks = 0;
    int nPass   = 0;

    multi_port_free_list #(.ENTRY_NUM(32), .DATA_WIDTH(6), .POP_WIDTH(2), .PUSH_WIDTH(2), .INIT_BASE(32)) dutA (
        .clk(clk), .rst(rst), .popReq(popReqA), .popData(popDataA), .allocatable(allocA),
        .pushReq(pushReqA), .pushData(pushDataA), .rollback(rollbackA), .rollbackCount(rbcA),
        .count(countA), .empty(emptyA));

    multi_port_free_list #(.ENTRY_NUM(24), .DATA_WIDTH(6), .POP_WIDTH(2), .PUSH_WIDTH(2), .INIT_BASE(32)) dutB (
        .clk(clk), .rst(rst), .popReq(popReqB), .popData(popDataB), .allocatable(allocB),
        .pushReq(pushReqB), .pushData(pushDataB), .rollback(rollbackB), .rollbackCount(rbcB),
        .count(countB), .empty(emptyB));

    multi_port_free_list_checker #(.ENTRY_NUM(32), .POP_WIDTH(2), .PUSH_WIDTH(2)) chkA (
        .clk(clk), .rst(rst), .enable(chkEnA), .popReq(popReqA), .pushReq(pushReqA),
        .rollback(rollbackA), .rollbackCount(rbcA), .allocatable(allocA), .count(countA));

    multi_port_free_list_checker #(.ENTRY_NUM(24), .POP_WIDTH(2), .PUSH_WIDTH(2)) chkB (
        .clk(clk), .rst(rst), .enable(1'b1), .popReq(popReqB), .pushReq(pushReqB),
        .rollback(rollbackB), .rollbackCount(rbcB), .allocatable(allocB), .count(countB));

    typedef struct {
        logic [1:0] pop;
        logic [1:0] push;
        logic [5:0] pd0;
        logic [5:0] pd1;
        logic       rb;
        logic [5:0] rbc;
        logic [1:0] chk;       // which lanes carry a grant to compare
        logic [5:0] exp0;
        logic [5:0] exp1;
        logic       expAlloc;
        logic [5:0] expCount;  // count after the clock edge
    } vec_t;

    typedef struct {
        int lane;
        int val;
    } exp_t;

    exp_t sbQ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(int pop, int push, int pd0, int pd1, int rb, int rbc,
                                int chk, int e0, int e1, int al, int cnt);
        vec_t v;
        v.pop = 2'(pop);   v.push = 2'(push);
        v.pd0 = 6'(pd0);   v.pd1  = 6'(pd1);
        v.rb  = 1'(rb);    v.rbc  = 6'(rbc);
        v.chk = 2'(chk);   v.exp0 = 6'(e0);  v.exp1 = 6'(e1);
        v.expAlloc = 1'(al);
        v.expCount = 6'(cnt);
        return v;
    endfunction

    // Called at posedge+1: drive, compare grants at the negedge, compare count after the edge.
    task automatic applyA(input string tag, input vec_t v);
        popReqA   = v.pop;
        pushReqA  = v.push;
        pushDataA = {v.pd1, v.pd0};
        rollbackA = v.rb;
        rbcA      = v.rbc;
        #4;
        if (v.chk[0]) check($sformatf("%s.lane0", tag), 32'(popDataA[5:0]), 32'(v.exp0));
        if (v.chk[1]) check($sformatf("%s.lane1", tag), 32'(popDataA[11:6]), 32'(v.exp1));
        check($sformatf("%s.alloc", tag), 32'(allocA), 32'(v.expAlloc));
        @(posedge clk);
        #1;
        check($sformatf("%s.count", tag), 32'(countA), 32'(v.expCount));
        check($sformatf("%s.empty", tag), 32'(emptyA), (v.expCount == 6'd0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        logic [1:0] pr, ps;
        int   rank;
        int   pv[2];
        int   freeQ[$];
        int   heldQ[$];
        exp_t e;

        rst = 1'b0;
        popReqA = 2'b11; pushReqA = 2'b00; pushDataA = 12'd0; rollbackA = 1'b0; rbcA = 6'd0;
        popReqB = 2'b00; pushReqB = 2'b00; pushDataB = 12'd0; rollbackB = 1'b0; rbcB = 6'd0;
        chkEnA = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("reset.count", 32'(countA), 32'd32);
        check("reset.empty", 32'(emptyA), 32'd0);
        check("reset.lane0", 32'(popDataA[5:0]), 32'd32);
        check("reset.lane1", 32'(popDataA[11:6]), 32'd33);
        check("reset.alloc", 32'(allocA), 32'd1);
        check("resetB.count", 32'(countB), 32'd24);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic grants and lane compaction
        tbl[0] = mk(3, 0, 0, 0, 0, 0, 3, 32, 33, 1, 30);
        tbl[1] = mk(3, 0, 0, 0, 0, 0, 3, 34, 35, 1, 28);
        tbl[2] = mk(2, 0, 0, 0, 0, 0, 2, 0, 36, 1, 27);
        tbl[3] = mk(1, 0, 0, 0, 0, 0, 1, 37, 0, 1, 26);
        tbl[4] = mk(0, 3, 5, 6, 0, 0, 0, 0, 0, 1, 28);
        tbl[5] = mk(3, 0, 0, 0, 0, 0, 3, 38, 39, 1, 26);
        for (int i = 0; i < 6; i++) applyA($sformatf("tbl%0d", i), tbl[i]);

        // Drain through index 31 so the head wraps onto the released slots 0 and 1
        for (int k = 0; k < 12; k++)
            applyA($sformatf("drain%0d", k), mk(3, 0, 0, 0, 0, 0, 3, 40 + 2*k, 41 + 2*k, 1, 24 - 2*k));
        applyA("wrap", mk(1, 0, 0, 0, 0, 0, 1, 5, 0, 1, 1));
        chkEnA = 1'b0;
        applyA("blocked", mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        chkEnA = 1'b1;
        applyA("last", mk(1, 0, 0, 0, 0, 0, 1, 6, 0, 1, 0));

        // Refill to 5, then balanced push/pop
        applyA("fill0", mk(0, 3, 7, 8, 0, 0, 0, 0, 0, 1, 2));
        applyA("fill1", mk(0, 3, 9, 10, 0, 0, 0, 0, 0, 1, 4));
        applyA("fill2", mk(0, 1, 11, 0, 0, 0, 0, 0, 0, 1, 5));
        applyA("pushpop", mk(3, 3, 12, 13, 0, 0, 3, 7, 8, 1, 5));
        applyA("after0", mk(3, 0, 0, 0, 0, 0, 3, 9, 10, 1, 3));
        applyA("after1", mk(3, 0, 0, 0, 0, 0, 3, 11, 12, 1, 1));

        // Reset mid-operation with requests pending
        popReqA = 2'b11; pushReqA = 2'b11; pushDataA = {6'd1, 6'd2};
        #2 rst = 1'b1;
        #1;
        check("midrst.count", 32'(countA), 32'd32);
        check("midrst.lane0", 32'(popDataA[5:0]), 32'd32);
        check("midrst.lane1", 32'(popDataA[11:6]), 32'd33);
        @(posedge clk);
        #1 rst = 1'b0;
        applyA("postrst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32));

        // Rollback: empty the list, recycle 32..35, allocate them, then rewind
        for (int k = 0; k < 16; k++)
            applyA($sformatf("empty%0d", k), mk(3, 0, 0, 0, 0, 0, 3, 32 + 2*k, 33 + 2*k, 1, 30 - 2*k));
        applyA("rbfill0", mk(0, 3, 32, 33, 0, 0, 0, 0, 0, 1, 2));
        applyA("rbfill1", mk(0, 3, 34, 35, 0, 0, 0, 0, 0, 1, 4));
        applyA("rbpop0", mk(3, 0, 0, 0, 0, 0, 3, 32, 33, 1, 2));
        applyA("rbpop1", mk(3, 0, 0, 0, 0, 0, 3, 34, 35, 1, 0));
        applyA("rollback", mk(3, 1, 40, 0, 1, 4, 0, 0, 0, 0, 5));
        applyA("rbgrant", mk(3, 0, 0, 0, 0, 0, 3, 32, 33, 1, 3));
        popReqA = 2'b00; pushReqA = 2'b00; rollbackA = 1'b0; rbcA = 6'd0;

        // Random balanced traffic on the 24-entry instance against a queue model
        for (int i = 0; i < 24; i++) freeQ.push_back(32 + i);
        for (int cyc = 0; cyc < 100; cyc++) begin
            pr = 2'($urandom_range(0, 3));
            if ($countones(pr) > freeQ.size()) pr = 2'b00;
            ps = 2'($urandom_range(0, 3));
            if ($countones(ps) > heldQ.size()) ps = 2'b00;
            pv[0] = 0; pv[1] = 0;
            for (int j = 0; j < 2; j++) if (ps[j]) pv[j] = heldQ.pop_front();
            rank = 0;
            for (int j = 0; j < 2; j++) begin
                if (pr[j]) begin
                    e.lane = j; e.val = freeQ[rank];
                    sbQ.push_back(e);
                    rank++;
                end
            end
            popReqB = pr; pushReqB = ps; pushDataB = {6'(pv[1]), 6'(pv[0])};
            #4;
            while (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                check($sformatf("rand%0d.lane%0d", cyc, e.lane), 32'(popDataB[e.lane*6 +: 6]), 32'(e.val));
            end
            check($sformatf("rand%0d.alloc", cyc), 32'(allocB), 32'd1);
            for (int j = 0; j < rank; j++) heldQ.push_back(freeQ.pop_front());
            for (int j = 0; j < 2; j++) if (ps[j]) freeQ.push_back(pv[j]);
            @(posedge clk);
            #1;
            check($sformatf("rand%0d.count", cyc), 32'(countB), 32'(freeQ.size()));
        end
        popReqB = 2'b00; pushReqB = 2'b00;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
